hazard_ctrl: RTL
================

# hazard_ctrl

Hazard and forwarding controller for the ALU execute stage of the RV32I pipeline. It compares the decoded source registers against the destinations in flight in the EX, MEM and WB stages. From that it drives the ALU's forwarding selects and forward data, and inserts load-use bubbles (nop_insert plus a decoder hold) through a small stall state machine. It sits beside the decoder/ALU boundary and honours the LSU freeze and the ALU's branch-mispredict flush.

## Interface
Parameters:
- LOAD_BUBBLES, 1, bubbles inserted on a load-use hazard; legal values 1 or 2.

Ports:
- CLK  input  1  clock
- RSTN  input  1  reset, asynchronous, active-low
- dec_vld  input  1  decoder holds a valid instruction
- dec_rs1 / dec_rs2  input  5  source register indices
- dec_rs1_used / dec_rs2_used  input  1  instruction actually reads rs1 / rs2
- alu_rd  input  5  EX-stage destination
- alu_rd_wen  input  1  EX-stage writes rd
- alu_load  input  1  EX-stage instruction is a load
- alu_out  input  32  EX-stage result
- alu_flush  input  1  mispredict flush from ALU
- mem_vld  input  1  MEM-stage result valid
- mem_rd  input  5  MEM-stage destination
- mem_rd_wen  input  1  MEM-stage writes rd
- mem_data  input  32  MEM-stage result (load data or passed ALU result)
- rf_wen  input  1  register-file write this cycle
- rf_rd  input  5  register-file write index
- rf_wdata  input  32  register-file write data
- lsu_ready  input  1  0 = pipeline frozen
- nop_insert  output  1  bubble into ALU stage
- dec_hold  output  1  hold fetch/decode registers
- rs1_forward / rs2_forward  output  1  forward select to ALU
- rs1_forward_data / rs2_forward_data  output  32  forward data to ALU

## Operation
- Forward select is combinational, evaluated independently per source s (rs1, rs2). Priority, highest first:
  - s==0 or s not used: no forward; select 0, data 0.
  - EX hit: alu_rd_wen, alu_rd==s, !alu_load. Data is alu_out.
  - MEM hit: mem_vld, mem_rd_wen, mem_rd==s. Data is mem_data.
  - WB hold hit: wbq_vld, wbq_rd==s. Data is wbq_data.
  - Otherwise: no forward.
- WB hold register (wbq_vld, wbq_rd, wbq_data):
  - On each non-frozen cycle: wbq_vld<=rf_wen, wbq_rd<=rf_rd, wbq_data<=rf_wdata.
  - This covers decode operands read one cycle before the regfile write.
- Load-use hazard: dec_vld, alu_rd_wen, alu_load, alu_rd!=0, and alu_rd matches a used rs1 or rs2.
- FSM states:
  - RUN:
    - On a hazard: nop_insert=1, dec_hold=1, cnt<=LOAD_BUBBLES-1. Next state is LSTALL if LOAD_BUBBLES=2, else stay RUN.
    - No hazard: outputs 0.
  - LSTALL:
    - nop_insert=1, dec_hold=1, cnt decrements.
    - Return to RUN when cnt==0 at the clock edge.
- alu_flush=1 overrides everything:
  - nop_insert=0, dec_hold=0, FSM<=RUN, cnt<=0.
  - Forwarding is unchanged.
- lsu_ready=0 freezes the block:
  - FSM, cnt and wbq hold their values.
  - nop_insert and dec_hold hold their current combinational value.
  - Forward outputs keep tracking inputs.
- Reset state: FSM=RUN, cnt=0, wbq_vld=0, wbq_rd=0, wbq_data=0. nop_insert and dec_hold are 0 while RSTN is low. Forward outputs follow the combinational rules.

## Timing
- Forward outputs have zero latency: same cycle as dec_rs*/stage inputs.
- Load-use:
  - nop_insert rises in the same cycle the hazard is visible.
  - With LOAD_BUBBLES=1: exactly 1 cycle high (excluding frozen cycles). The next cycle the load is in MEM and is forwarded from mem_data.
  - With LOAD_BUBBLES=2: exactly 2 cycles high. The load result comes from the WB hold register.
- Simultaneous hazard and alu_flush: the flush wins and no bubble is inserted.
- Flush mid-LSTALL: the stall is cancelled and the FSM is in RUN the next cycle.
- Reset asserted mid-stall: immediate return to RUN, outputs 0.
- EX and MEM hitting the same register: EX wins (it is the younger producer).

## Configuration
- HAZARD_PERF_EN defined:
  - Adds outputs perf_stall_cnt[31:0] (non-frozen cycles with nop_insert=1) and perf_fwd_cnt[31:0] (non-frozen cycles with dec_vld and any forward select=1).
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- HAZARD_PERF_EN undefined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- EX forward: alu_rd=5, alu_rd_wen=1, alu_load=0, alu_out=0x1234; decode with rs1=5 used -> rs1_forward=1, rs1_forward_data=0x1234, nop_insert=0.
- Load-use, LOAD_BUBBLES=1: alu_rd=7 load; decode rs2=7 used -> nop_insert=1 and dec_hold=1 for one cycle. Next cycle mem_rd=7, mem_data=0xCAFE -> rs2_forward_data=0xCAFE.
- Priority and x0: alu_rd=3 with 0xAA, mem_rd=3 with 0xBB -> data 0xAA. rs1=0 with alu_rd=0 -> rs1_forward=0.
- Freeze: hazard with lsu_ready=0 for 3 cycles -> nop_insert stays 1 and the FSM does not advance. Bubble completes 1 cycle after lsu_ready=1.
- Flush: hazard and alu_flush=1 in the same cycle -> nop_insert=0, dec_hold=0. With LOAD_BUBBLES=2, flush on the LSTALL cycle -> RUN next cycle.
- WB hold: rf_wen=1, rf_rd=9, rf_wdata=0x55, then decode rs1=9 with no EX/MEM match -> rs1_forward_data=0x55. With HAZARD_PERF_EN, perf_fwd_cnt increments by 1.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Hazard and forwarding controller for the RV32I ALU execute stage.
// It compares the decoded source registers against the destinations held in
// the EX, MEM and WB stages. From that it drives the ALU forwarding selects and
// data, and inserts load-use bubbles through a small stall state machine.
//
// Parameters
//   LOAD_BUBBLES      bubbles inserted on a load-use hazard (1 or 2)
//
// Ports
//   CLK, RSTN         clock, asynchronous active-low reset
//   dec_*             decoded instruction: valid, rs1/rs2 and their use flags
//   alu_*             EX stage: rd, write enable, load flag, result, flush
//   mem_*             MEM stage: valid, rd, write enable, result
//   rf_*              register-file write port of this cycle
//   lsu_ready         0 freezes the block
//   nop_insert        bubble into the ALU stage
//   dec_hold          hold the fetch/decode registers
//   rs*_forward       forward select for each ALU operand
//   rs*_forward_data  forward data for each ALU operand
//
// Optional feature (macro HAZARD_PERF_EN)
//   perf_stall_cnt    saturating count of non-frozen cycles with nop_insert
//   perf_fwd_cnt      saturating count of non-frozen cycles with dec_vld and
//                     at least one forward select
module hazard_ctrl #(
   parameter int LOAD_BUBBLES = 1
) (
   input  logic        CLK,
   input  logic        RSTN,
   input  logic        dec_vld,
   input  logic [4:0]  dec_rs1,
   input  logic [4:0]  dec_rs2,
   input  logic        dec_rs1_used,
   input  logic        dec_rs2_used,
   input  logic [4:0]  alu_rd,
   input  logic        alu_rd_wen,
   input  logic        alu_load,
   input  logic [31:0] alu_out,
   input  logic        alu_flush,
   input  logic        mem_vld,
   input  logic [4:0]  mem_rd,
   input  logic        mem_rd_wen,
   input  logic [31:0] mem_data,
   input  logic        rf_wen,
   input  logic [4:0]  rf_rd,
   input  logic [31:0] rf_wdata,
   input  logic        lsu_ready,
   output logic        nop_insert,
   output logic        dec_hold,
   output logic        rs1_forward,
   output logic        rs2_forward,
   output logic [31:0] rs1_forward_data,
   output logic [31:0] rs2_forward_data
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_fwd_cnt
`endif
);

   typedef enum logic {
      RUN,
      LSTALL
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [1:0]  cnt;
   logic [1:0]  cnt_next;

   logic        wbq_vld;
   logic [4:0]  wbq_rd;
   logic [31:0] wbq_data;

   logic        load_use;

   // Forward pick for one source, returning {select, data}. A load in EX has
   // no data yet, so it never forwards; the younger EX producer beats MEM,
   // and MEM beats the WB hold register.
   function automatic logic [32:0] fwd_pick(
      input logic [4:0]  src,
      input logic        used,
      input logic [4:0]  a_rd,
      input logic        a_wen,
      input logic        a_load,
      input logic [31:0] a_out,
      input logic        m_vld,
      input logic        m_wen,
      input logic [4:0]  m_rd,
      input logic [31:0] m_data,
      input logic        w_vld,
      input logic [4:0]  w_rd,
      input logic [31:0] w_data
   );
      logic [32:0] pick;
      pick = '0;
      if (src == 5'd0 || !used) begin
         pick = '0;
      end else if (a_wen && a_rd == src && !a_load) begin
         pick = {1'b1, a_out};
      end else if (m_vld && m_wen && m_rd == src) begin
         pick = {1'b1, m_data};
      end else if (w_vld && w_rd == src) begin
         pick = {1'b1, w_data};
      end
      return pick;
   endfunction

   // Zero-latency forwarding for both ALU operands.
   always_comb begin
      {rs1_forward, rs1_forward_data} = fwd_pick(dec_rs1, dec_rs1_used,
         alu_rd, alu_rd_wen, alu_load, alu_out, mem_vld, mem_rd_wen, mem_rd,
         mem_data, wbq_vld, wbq_rd, wbq_data);
      {rs2_forward, rs2_forward_data} = fwd_pick(dec_rs2, dec_rs2_used,
         alu_rd, alu_rd_wen, alu_load, alu_out, mem_vld, mem_rd_wen, mem_rd,
         mem_data, wbq_vld, wbq_rd, wbq_data);
   end

   // A load in EX whose destination is read by the decoded instruction.
   assign load_use = dec_vld && alu_rd_wen && alu_load && (alu_rd != 5'd0) &&
                     ((dec_rs1_used && dec_rs1 == alu_rd) ||
                      (dec_rs2_used && dec_rs2 == alu_rd));

   // Stall FSM next state and outputs. The hazard cycle is itself the first
   // bubble; LSTALL covers the remaining ones, leaving on the edge where the
   // count runs out. A flush cancels everything, and the bubble outputs are
   // forced low while reset is asserted.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      nop_insert = 1'b0;
      dec_hold   = 1'b0;
      if (alu_flush) begin
         state_next = RUN;
         cnt_next   = 2'd0;
      end else begin
         case (state)
            RUN: begin
               if (load_use) begin
                  nop_insert = 1'b1;
                  dec_hold   = 1'b1;
                  cnt_next   = 2'(LOAD_BUBBLES - 1);
                  state_next = (LOAD_BUBBLES == 2) ? LSTALL : RUN;
               end
            end
            LSTALL: begin
               nop_insert = 1'b1;
               dec_hold   = 1'b1;
               if (cnt <= 2'd1) begin
                  cnt_next   = 2'd0;
                  state_next = RUN;
               end else begin
                  cnt_next = cnt - 2'd1;
               end
            end
            default: begin
               state_next = RUN;
               cnt_next   = 2'd0;
            end
         endcase
      end
      if (!RSTN) begin
         nop_insert = 1'b0;
         dec_hold   = 1'b0;
      end
   end

   // State register. A frozen pipeline holds the FSM, but a flush still
   // takes effect so that a cancelled stall cannot resume later.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state <= RUN;
         cnt   <= 2'd0;
      end else if (lsu_ready || alu_flush) begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // WB hold register: the regfile write of the previous non-frozen cycle,
   // for operands that decode read just before that write landed.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         wbq_vld  <= 1'b0;
         wbq_rd   <= 5'd0;
         wbq_data <= 32'd0;
      end else if (lsu_ready) begin
         wbq_vld  <= rf_wen;
         wbq_rd   <= rf_rd;
         wbq_data <= rf_wdata;
      end
   end

`ifdef HAZARD_PERF_EN
   // Saturating performance counters, advanced on non-frozen cycles only.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         perf_stall_cnt <= 32'd0;
         perf_fwd_cnt   <= 32'd0;
      end else if (lsu_ready) begin
         if (nop_insert && perf_stall_cnt != 32'hFFFF_FFFF) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         end
         if (dec_vld && (rs1_forward || rs2_forward) &&
             perf_fwd_cnt != 32'hFFFF_FFFF) begin
            perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
         end
      end
   end
`endif

endmodule
